// File: rtl/spi_master.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames.
// Single bytes or bursts with chip select held low between bytes; SCK is
// derived from clk_i by a half-period divider.
module spi_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       last_i,
  input  logic [7:0] tx_data_i,
  output logic [7:0] rx_data_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       spi_sck_o,
  output logic       spi_mosi_o,
  input  logic       spi_miso_i,
  output logic       spi_cs_o
);

  localparam int unsigned DIV_W  = $clog2(CLK_DIV + 1);
  localparam int unsigned CS_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned CS_W   = $clog2(CS_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_WAIT  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] div_cnt, div_cnt_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [CS_W-1:0]  cs_cnt, cs_cnt_n;
  logic [6:0]       tx_sh, tx_sh_n;
  logic [7:0]       rx_sh, rx_sh_n;
  logic             last_byte, last_byte_n;
  logic             fin, fin_n;
  logic             sck, sck_n;
  logic             mosi, mosi_n;
  logic             cs, cs_n;
  logic             busy, busy_n;
  logic             done, done_n;
  logic [7:0]       rx_data, rx_data_n;

  logic accept;
  logic tick;
  logic setup_done;
  logic hold_done;

  // A new byte is taken only when idle or parked in a burst with busy low.
  assign accept     = start_i && !busy && (state == S_IDLE || state == S_WAIT);
  assign tick       = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign setup_done = (cs_cnt == CS_W'(CS_SETUP - 1));
  // Hold count starts at 1 on entry: the done cycle already follows the last fall.
  assign hold_done  = (cs_cnt >= CS_W'(CS_HOLD - 1));

  assign rx_data_o  = rx_data;
  assign busy_o     = busy;
  assign done_o     = done;
  assign spi_sck_o  = sck;
  assign spi_mosi_o = mosi;
  assign spi_cs_o   = cs;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state selection.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept) state_n = S_SETUP;
      S_SETUP: if (setup_done) state_n = S_XFER;
      S_XFER:  if (fin) state_n = last_byte ? S_HOLD : S_WAIT;
      S_WAIT:  if (accept) state_n = S_XFER;
      S_HOLD:  if (hold_done) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Next values of the datapath and registered outputs.
  always_comb begin
    div_cnt_n   = div_cnt;
    bit_cnt_n   = bit_cnt;
    cs_cnt_n    = cs_cnt;
    tx_sh_n     = tx_sh;
    rx_sh_n     = rx_sh;
    last_byte_n = last_byte;
    fin_n       = fin;
    sck_n       = sck;
    mosi_n      = mosi;
    cs_n        = cs;
    busy_n      = busy;
    done_n      = 1'b0;
    rx_data_n   = rx_data;
    case (state)
      S_IDLE: begin
        if (accept) begin
          tx_sh_n     = tx_data_i[6:0];
          last_byte_n = last_i;
          mosi_n      = tx_data_i[7];
          cs_n        = 1'b0;
          busy_n      = 1'b1;
          cs_cnt_n    = '0;
        end
      end
      S_SETUP: begin
        cs_cnt_n = cs_cnt + CS_W'(1);
        if (setup_done) begin
          div_cnt_n = '0;
          bit_cnt_n = '0;
        end
      end
      S_XFER: begin
        if (fin) begin
          fin_n     = 1'b0;
          done_n    = 1'b1;
          rx_data_n = rx_sh;
          cs_cnt_n  = CS_W'(1);
        end else begin
          div_cnt_n = tick ? '0 : div_cnt + DIV_W'(1);
          if (tick) begin
            if (!sck) begin
              sck_n   = 1'b1;
              rx_sh_n = {rx_sh[6:0], spi_miso_i};
            end else begin
              sck_n     = 1'b0;
              bit_cnt_n = bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                fin_n = 1'b1;
              end else begin
                mosi_n  = tx_sh[6];
                tx_sh_n = {tx_sh[5:0], 1'b0};
              end
            end
          end
        end
      end
      S_WAIT: begin
        busy_n = 1'b0;
        if (accept) begin
          tx_sh_n     = tx_data_i[6:0];
          last_byte_n = last_i;
          mosi_n      = tx_data_i[7];
          busy_n      = 1'b1;
          div_cnt_n   = '0;
          bit_cnt_n   = '0;
        end
      end
      S_HOLD: begin
        cs_cnt_n = cs_cnt + CS_W'(1);
        if (hold_done) begin
          cs_n   = 1'b1;
          busy_n = 1'b0;
        end
      end
      default: begin
        cs_n   = 1'b1;
        sck_n  = 1'b0;
        busy_n = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset abandons any partial byte.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      cs_cnt    <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      last_byte <= 1'b0;
      fin       <= 1'b0;
      sck       <= 1'b0;
      mosi      <= 1'b0;
      cs        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      rx_data   <= '0;
    end else begin
      div_cnt   <= div_cnt_n;
      bit_cnt   <= bit_cnt_n;
      cs_cnt    <= cs_cnt_n;
      tx_sh     <= tx_sh_n;
      rx_sh     <= rx_sh_n;
      last_byte <= last_byte_n;
      fin       <= fin_n;
      sck       <= sck_n;
      mosi      <= mosi_n;
      cs        <= cs_n;
      busy      <= busy_n;
      done      <= done_n;
      rx_data   <= rx_data_n;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV=2 and CLK_DIV=1) each driven
// by directed and random byte requests against a behavioural SPI slave.
module tb_spi_master;

  localparam int unsigned SU = 2;
  localparam int unsigned HD = 2;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    bit         last;
    int         due;
  } exp_t;

  typedef struct {
    logic [7:0] b;
    int         rises;
    int         bad;
  } cap_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  bit fin_flag [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_u
    localparam int unsigned CD = (g == 0) ? 2 : 1;

    logic       rst, start, last, miso;
    logic [7:0] tx, rx;
    logic       busy, done, sck, mosi, cs;

    spi_master #(.CLK_DIV(CD), .CS_SETUP(SU), .CS_HOLD(HD)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .start_i   (start),
      .last_i    (last),
      .tx_data_i (tx),
      .rx_data_o (rx),
      .busy_o    (busy),
      .done_o    (done),
      .spi_sck_o (sck),
      .spi_mosi_o(mosi),
      .spi_miso_i(miso),
      .spi_cs_o  (cs)
    );

    exp_t       exp_q [$];
    logic [7:0] sl_q  [$];
    cap_t       cap_q [$];
    bit         open = 1'b0;

    task automatic ck(input string nm, input logic [31:0] act, input logic [31:0] req);
      chk($sformatf("u%0d_%s", g, nm), act, req);
    endtask

    // Behavioural mode-0 slave: shifts MISO out on falls, captures MOSI on rises.
    int         sbit = 0, rises = 0, hi_len = 0, bad = 0;
    bit         loaded = 1'b0, prev = 1'b0;
    logic [7:0] sbyte = 8'h00, cap = 8'h00;
    always @(negedge clk) begin
      if (rst || cs) begin
        sbit = 0; rises = 0; bad = 0; loaded = 1'b0; miso = 1'b0; prev = sck;
      end else begin
        if (sck) begin
          hi_len = prev ? hi_len + 1 : 1;
          if (!prev) begin
            cap = {cap[6:0], mosi};
            rises++;
          end
        end
        if (!sck && prev) begin
          if (hi_len != int'(CD)) bad++;
          sbit++;
          if (sbit == 8) begin
            cap_q.push_back('{b: cap, rises: rises, bad: bad});
            sbit = 0; rises = 0; bad = 0; loaded = 1'b0;
          end else begin
            miso = sbyte[3'(7 - sbit)];
          end
        end
        if (!loaded && sbit == 0 && sl_q.size() > 0) begin
          sbyte  = sl_q.pop_front();
          miso   = sbyte[7];
          loaded = 1'b1;
        end
        prev = sck;
      end
    end

    // Monitor: pops the scoreboard on every done pulse.
    int post_due = 0;
    bit post_on = 1'b0, post_last = 1'b0;
    always @(negedge clk) begin
      exp_t e;
      cap_t c;
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          ck("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          ck("rx_data", rx, e.rx);
          ck("done_cycle", cyc, e.due);
          ck("cs_at_done", cs, 0);
          if (cap_q.size() > 0) begin
            c = cap_q.pop_front();
            ck("mosi_byte", c.b, e.tx);
            ck("sck_rises", c.rises, 8);
            ck("sck_high_len_errs", c.bad, 0);
          end else begin
            ck("mosi_frame_missing", 0, 1);
          end
          post_due  = cyc + 1;
          post_last = e.last;
          post_on   = 1'b1;
        end
      end
      if (post_on && cyc == post_due) begin
        ck("cs_after_done", cs, post_last);
        ck("busy_after_done", busy, 0);
        ck("sck_after_done", sck, 0);
        post_on = 1'b0;
      end
    end

    task automatic issue(input logic [7:0] t, input bit l, input logic [7:0] s);
      int n;
      exp_t e;
      n = 0;
      while (busy !== 1'b0 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 2000) ck("busy_timeout", 1, 0);
      if (open) ck("cs_low_in_burst", cs, 0);
      e.tx   = t;
      e.rx   = s;
      e.last = l;
      e.due  = cyc + 1 + 1 + (open ? 0 : int'(SU)) + 16 * int'(CD);
      exp_q.push_back(e);
      sl_q.push_back(s);
      start = 1'b1; tx = t; last = l;
      @(negedge clk);
      start = 1'b0;
      open  = !l;
    endtask

    task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0) && n < 5000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 5000) ck("idle_timeout", 1, 0);
    endtask

    initial begin
      int n, r;
      bit p, gap_bad, l;
      rst = 1'b1; start = 1'b0; last = 1'b0; tx = 8'h00;
      repeat (3) @(negedge clk);
      ck("rst_cs", cs, 1);
      ck("rst_sck", sck, 0);
      ck("rst_mosi", mosi, 0);
      ck("rst_busy", busy, 0);
      ck("rst_done", done, 0);
      ck("rst_rx", rx, 0);
      rst = 1'b0;
      @(negedge clk);

      // Single byte with CS release.
      issue(8'hA5, 1'b1, 8'h3C);
      wait_idle();

      // Three-byte burst, CS held low.
      issue(8'h01, 1'b0, 8'($urandom));
      issue(8'h80, 1'b0, 8'($urandom));
      issue(8'hFF, 1'b1, 8'($urandom));
      wait_idle();

      // start_i hammered while busy (including the done cycle) is ignored.
      issue(8'($urandom), 1'b1, 8'h5A);
      n = 0;
      while (busy === 1'b1 && n < 2000) begin
        start = 1'b1; tx = 8'($urandom); last = 1'($urandom_range(0, 1));
        @(negedge clk);
        n++;
      end
      start = 1'b0;
      wait_idle();
      repeat (4) @(negedge clk);

      // Reset at the 4th SCK rise abandons the byte.
      issue(8'($urandom), 1'b1, 8'h96);
      r = 0; p = 1'b0; n = 0;
      while (r < 4 && n < 2000) begin
        @(negedge clk);
        n++;
        if (sck && !p) r++;
        p = sck;
      end
      ck("rst_4th_rise_seen", r, 4);
      rst = 1'b1;
      exp_q.delete(); sl_q.delete(); cap_q.delete();
      open = 1'b0;
      @(negedge clk);
      ck("midrst_cs", cs, 1);
      ck("midrst_sck", sck, 0);
      ck("midrst_busy", busy, 0);
      ck("midrst_rx", rx, 0);
      ck("midrst_done", done, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      issue(8'hC3, 1'b1, 8'hC3);
      wait_idle();

      // Long WAIT gap inside a burst, then resume without CS setup.
      issue(8'($urandom), 1'b0, 8'($urandom));
      wait_idle();
      gap_bad = 1'b0;
      repeat (100) begin
        @(negedge clk);
        if (sck !== 1'b0 || cs !== 1'b0 || busy !== 1'b0) gap_bad = 1'b1;
      end
      ck("wait_gap_lines", gap_bad, 0);
      issue(8'($urandom), 1'b1, 8'($urandom));
      wait_idle();

      // Random mix of single bytes and bursts.
      for (int i = 0; i < 12; i++) begin
        l = (i == 11) ? 1'b1 : 1'($urandom_range(0, 1));
        issue(8'($urandom), l, 8'($urandom));
        repeat ($urandom_range(0, 4)) @(negedge clk);
      end
      wait_idle();
      repeat (4) @(negedge clk);
      ck("scoreboard_empty", exp_q.size(), 0);
      ck("slave_frames_left", cap_q.size(), 0);
      fin_flag[g] = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(fin_flag[0] && fin_flag[1]) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) chk("global_timeout", 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
